// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: width rules, identity kernel,
// and the round/shift/abs/clamp used by this block and the gradient-magnitude stage.
package conv_pkg;

    typedef struct packed {
        logic [31:0] value;
        logic        sat;
    } clamp_t;

    function automatic int prod_width(input int pix_w, input int coef_w);
        return pix_w + coef_w + 1;
    endfunction

    function automatic int sum_width(input int k, input int pix_w, input int coef_w);
        return prod_width(pix_w, coef_w) + $clog2(k * k);
    endfunction

    function automatic int identity_coef(input int k, input int shift, input int idx);
        return (idx == (k * k) / 2) ? (1 << shift) : 0;
    endfunction

    // Round-half-up, arithmetic shift, optional magnitude, then clamp to [0, 2^pix_w-1].
    function automatic clamp_t round_clamp(input logic signed [63:0] sum, input int shift,
                                           input int pix_w, input logic abs_mode);
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        clamp_t             r;
        v     = sum;
        max_v = (64'sd1 <<< pix_w) - 64'sd1;
        if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
        v = v >>> shift;
        if (abs_mode && (v < 64'sd0)) v = -v;
        if (v < 64'sd0) begin
            r.value = '0;
            r.sat   = 1'b1;
        end else if (v > max_v) begin
            r.value = max_v[31:0];
            r.sat   = 1'b1;
        end else begin
            r.value = v[31:0];
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_row_sum.sv
// Registered sum of the K signed products belonging to one kernel row.
module conv_row_sum #(
    parameter int K      = 5,
    parameter int PROD_W = 21
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic signed [PROD_W-1:0]             prod [K],
    output logic signed [PROD_W+$clog2(K)-1:0]   row_sum
);

    localparam int ROW_W = PROD_W + $clog2(K);

    logic signed [ROW_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int c = 0; c < K; c++) acc = acc + ROW_W'(prod[c]);
    end

    always_ff @(posedge clk) begin
        if (rst) row_sum <= '0;
        else if (en) row_sum <= acc;
    end

endmodule

// File: rtl/conv_kernel_pipe.sv
// K x K convolution: shadow/active coefficient banks, multiply, row sums, full sum,
// then round/shift/abs/clamp. Four enabled stages from accept to out_valid.
module conv_kernel_pipe
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 12,
    parameter int SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [K*K*PIX_W-1:0]       pixel_data,
    input  logic                       abs_mode,
    input  logic                       coef_wr,
    input  logic [$clog2(K*K)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       coef_commit,
    output logic                       out_valid,
    output logic [PIX_W-1:0]           conv_data,
    output logic                       sat
);

    localparam int N      = K * K;
    localparam int PROD_W = prod_width(PIX_W, COEF_W);
    localparam int ROW_W  = PROD_W + $clog2(K);
    localparam int SUM_W  = sum_width(K, PIX_W, COEF_W);

    logic signed [COEF_W-1:0] shadow [N];
    logic signed [COEF_W-1:0] active [N];

    // Commit copies the pre-edge shadow, so a same-cycle write misses this commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= COEF_W'(identity_coef(K, SHIFT, i));
                active[i] <= COEF_W'(identity_coef(K, SHIFT, i));
            end
        end else begin
            if (coef_commit) active <= shadow;
            if (coef_wr && (32'(coef_addr) < N)) shadow[coef_addr] <= coef_data;
        end
    end

    logic signed [PROD_W-1:0] prod_c  [K][K];
    logic signed [PROD_W-1:0] s1_prod [K][K];
    logic                     s1_valid, s1_abs;

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_c[r][c] = PROD_W'($signed({1'b0, pixel_data[(r*K+c)*PIX_W +: PIX_W]}))
                             * PROD_W'(active[r*K+c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_abs   <= 1'b0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) s1_prod[r][c] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_abs   <= abs_mode;
            s1_prod  <= prod_c;
        end
    end

    logic signed [ROW_W-1:0] s2_row [K];
    logic                    s2_valid, s2_abs;

    for (genvar r = 0; r < K; r++) begin : g_row
        conv_row_sum #(.K(K), .PROD_W(PROD_W)) u_row (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .prod    (s1_prod[r]),
            .row_sum (s2_row[r])
        );
    end

    logic signed [SUM_W-1:0] sum_c, s3_sum;
    logic                    s3_valid, s3_abs;

    always_comb begin
        sum_c = '0;
        for (int r = 0; r < K; r++) sum_c = sum_c + SUM_W'(s2_row[r]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_abs   <= 1'b0;
            s3_valid <= 1'b0;
            s3_abs   <= 1'b0;
            s3_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_abs   <= s1_abs;
            s3_valid <= s2_valid;
            s3_abs   <= s2_abs;
            s3_sum   <= sum_c;
        end
    end

    clamp_t rc;
    logic   unused_hi;

    assign rc        = round_clamp(64'(s3_sum), SHIFT, PIX_W, s3_abs);
    assign unused_hi = ^rc.value[31:PIX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            conv_data <= '0;
            sat       <= 1'b0;
        end else if (en) begin
            out_valid <= s3_valid;
            conv_data <= rc.value[PIX_W-1:0];
            sat       <= rc.sat;
        end
    end

endmodule

// File: tb/tb_conv_kernel_pipe.sv
// Directed bench for conv_kernel_pipe: stimulus pushes {sat, data} into a queue,
// a monitor pops and compares on every enabled out_valid cycle.
module tb_conv_kernel_pipe;

    localparam int K      = 5;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 12;
    localparam int SHIFT  = 8;
    localparam int N      = K * K;
    localparam int AW     = $clog2(N);

    logic                     clk = 1'b0;
    logic                     rst, en, in_valid, abs_mode, coef_wr, coef_commit;
    logic [N*PIX_W-1:0]       pixel_data;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic [PIX_W-1:0]         conv_data;
    logic                     sat;

    int checks = 0;
    int errors = 0;
    logic [PIX_W:0] exp_q[$];

    always #5 clk = ~clk;

    conv_kernel_pipe #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .pixel_data  (pixel_data),
        .abs_mode    (abs_mode),
        .coef_wr     (coef_wr),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .out_valid   (out_valid),
        .conv_data   (conv_data),
        .sat         (sat)
    );

    // Monitor / scoreboard
    initial begin
        logic [PIX_W:0] exp_v;
        forever begin
            @(negedge clk);
            if (en && out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data=%0d sat=%0b, expected no output",
                             conv_data, sat);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({sat, conv_data} !== exp_v) begin
                        errors++;
                        $display("FAIL scoreboard: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                                 conv_data, sat, exp_v[PIX_W-1:0], exp_v[PIX_W]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*PIX_W-1:0] w, input logic am, input logic [PIX_W:0] exp_v);
        in_valid   = 1'b1;
        pixel_data = w;
        abs_mode   = am;
        exp_q.push_back(exp_v);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int value);
        coef_wr   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_W'(value);
        cycle();
        coef_wr = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        cycle();
        coef_commit = 1'b0;
    endtask

    task automatic load_gauss(input int mult);
        int g[5] = '{1, 4, 6, 4, 1};
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) write_coef(r*K + c, g[r] * g[c] * mult);
        commit();
    endtask

    // Sobel-x x64 in the centre 3x3, zero border
    task automatic load_sobel();
        int v;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                v = 0;
                if (r >= 1 && r <= 3 && c >= 1 && c <= 3)
                    v = (c - 2) * ((r == 2) ? 2 : 1) * 64;
                write_coef(r*K + c, v);
            end
        end
        commit();
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++) write_coef(i, (i == 12) ? 256 : 0);
        commit();
    endtask

    function automatic logic [N*PIX_W-1:0] uniform(input int v);
        logic [N*PIX_W-1:0] w;
        for (int i = 0; i < N; i++) w[i*PIX_W +: PIX_W] = PIX_W'(v);
        return w;
    endfunction

    function automatic logic [N*PIX_W-1:0] mid_only(input int v);
        logic [N*PIX_W-1:0] w;
        w = '0;
        w[12*PIX_W +: PIX_W] = PIX_W'(v);
        return w;
    endfunction

    function automatic logic [N*PIX_W-1:0] split_cols(input int split, input int left, input int right);
        logic [N*PIX_W-1:0] w;
        for (int i = 0; i < N; i++) w[i*PIX_W +: PIX_W] = PIX_W'(((i % K) < split) ? left : right);
        return w;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) cycle();
    endtask

    initial begin
        int lat, run, max_run, cnt;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; abs_mode = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
        pixel_data = '0;
        repeat (2) cycle();
        rst = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_conv_data", int'(conv_data), 0);
        check("reset_sat", int'(sat), 0);

        // Identity kernel, latency measured from the accepting edge
        send(uniform(100), 1'b0, {1'b0, 8'd100});
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency", lat, 4);
        drain("identity_uniform");
        send(mid_only(37), 1'b0, {1'b0, 8'd37});
        drain("identity_mid");

        // Gaussian, then four back-to-back windows
        load_gauss(1);
        send(uniform(200), 1'b0, {1'b0, 8'd200});
        drain("gauss_200");
        send(uniform(50), 1'b0, {1'b0, 8'd50});
        send(uniform(60), 1'b0, {1'b0, 8'd60});
        send(uniform(70), 1'b0, {1'b0, 8'd70});
        send(uniform(80), 1'b0, {1'b0, 8'd80});
        run = 0; max_run = 0; cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) begin
                run++;
                cnt++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end
        check("back_to_back_run", max_run, 4);
        check("back_to_back_count", cnt, 4);
        drain("back_to_back");

        // Stall three cycles mid-stream with a window held at the input
        send(uniform(10), 1'b0, {1'b0, 8'd10});
        send(uniform(20), 1'b0, {1'b0, 8'd20});
        send(uniform(30), 1'b0, {1'b0, 8'd30});
        send(uniform(40), 1'b0, {1'b0, 8'd40});
        send(uniform(50), 1'b0, {1'b0, 8'd50});
        en = 1'b0;
        in_valid = 1'b1;
        pixel_data = uniform(60);
        repeat (3) begin
            @(negedge clk);
            check("stall_held_valid", int'(out_valid), 1);
            check("stall_held_data", int'(conv_data), 20);
            cycle();
        end
        en = 1'b1;
        exp_q.push_back({1'b0, 8'd60});
        cycle();
        in_valid = 1'b0;
        send(uniform(70), 1'b0, {1'b0, 8'd70});
        drain("stall");

        // Gaussian x2 saturates high
        load_gauss(2);
        send(uniform(255), 1'b0, {1'b1, 8'd255});
        drain("gauss_sat");

        // Sobel-x: rising edge, then mirrored in both modes
        load_sobel();
        send(split_cols(3, 0, 255), 1'b0, {1'b0, 8'd255});
        send(split_cols(2, 255, 0), 1'b1, {1'b0, 8'd255});
        send(split_cols(2, 255, 0), 1'b0, {1'b1, 8'd0});
        drain("sobel");

        // Same-cycle commit and write: write misses the commit, lands in the next one
        load_identity();
        coef_commit = 1'b1;
        write_coef(12, 512);
        coef_commit = 1'b1;
        send(mid_only(37), 1'b0, {1'b0, 8'd37});
        coef_commit = 1'b0;
        send(mid_only(37), 1'b0, {1'b0, 8'd74});
        drain("commit_wr");

        // Reset with three windows in flight
        send(uniform(90), 1'b0, {1'b0, 8'd180});
        send(uniform(91), 1'b0, {1'b0, 8'd182});
        send(uniform(92), 1'b0, {1'b0, 8'd184});
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        check("rst_flush_valid", int'(out_valid), 0);
        repeat (8) cycle();
        send(mid_only(37), 1'b0, {1'b0, 8'd37});
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
